ibex_wb_queue: RTL
==================

// Module: ibex_wb_queue
// PURPOSE
//  Multi-entry writeback queue between ID/EX and the register file; successor of the single-entry WB stage.
//  Holds up to Depth issued instructions, retires them strictly in order (at most one per cycle),
//  merges LSU load data, and tracks outstanding loads/stores and retire perf events.
//  Optional register-file forwarding/hazard lookup over all queued entries.
// PARAMETERS
//  Depth     2     number of queue entries, >=1; pointers wrap Depth-1 -> 0 (no power-of-two requirement)
//  ResetAll  1'b0  1: entry payloads async-reset to 0; 0: payloads unreset, only valid bits/pointers reset
// PORTS
//  clk_i                          in   1   clock
//  rst_ni                         in   1   async reset, active low
//  en_wb_i                        in   1   enqueue request (instruction leaves EX)
//  instr_type_wb_i                in   2   wb_instr_type_e: LOAD=0, STORE=1, OTHER=2
//  pc_id_i                        in   32  PC of enqueued instruction
//  instr_is_compressed_id_i       in   1   enqueued instr is compressed
//  instr_perf_count_id_i          in   1   enqueued instr counts for perf
//  rf_waddr_id_i/rf_wdata_id_i/rf_we_id_i  in 5/32/1  RF write from EX
//  rf_wdata_lsu_i/rf_we_lsu_i     in   32/1  load data / write enable from LSU
//  lsu_resp_valid_i/lsu_resp_err_i in  1/1   LSU response for head load/store
//  fwd_raddr_i                    in   5   forwarding lookup address
//  ready_wb_o                     out  1   queue can accept en_wb_i this cycle
//  rf_waddr_wb_o/rf_wdata_wb_o/rf_we_wb_o  out 5/32/1  RF write port (head)
//  outstanding_load_wb_o/outstanding_store_wb_o  out 1/1  any valid LOAD/STORE entry
//  pc_wb_o                        out  32  head PC (0 when empty)
//  instr_done_wb_o                out  1   head retires this cycle
//  perf_instr_ret_wb_o/perf_instr_ret_compressed_wb_o  out 1/1  retire perf pulses
//  fwd_hit_o/fwd_stall_o/fwd_wdata_o  out 1/1/32  forwarding result
//  count_o                        out  $clog2(Depth+1)  valid entries
// BEHAVIOUR
//  - Reset: all valid bits, pointers, count 0; every output 0 except ready_wb_o=1.
//  - head_done = head_valid & (head_type==OTHER | lsu_resp_valid_i); retire on head_done, head ptr advances.
//  - ready_wb_o = (count_o < Depth) | head_done; enqueue when en_wb_i & ready_wb_o; en_wb_i while not ready is protocol error (assert).
//  - Enqueue into tail; earliest retire of that entry is next cycle (latency 1). Enqueue+retire same cycle: count unchanged.
//  - Full + head_done + en_wb_i: tail slot freed and refilled same cycle, no bubble.
//  - lsu_resp_valid_i with head not LOAD/STORE or queue empty: ignored, assertion fires.
//  - RF write: rf_we_wb_o = (head_valid & head_we & head_type!=LOAD) | rf_we_lsu_i;
//    rf_wdata_wb_o = AND-OR of head wdata and rf_wdata_lsu_i by their enables; rf_waddr_wb_o = head waddr.
//  - perf_instr_ret_wb_o = head_done & head_count & ~(lsu_resp_valid_i & lsu_resp_err_i); compressed = & head_compressed.
//  - Forwarding: youngest valid entry with we & waddr==fwd_raddr_i & fwd_raddr_i!=0 wins;
//    non-LOAD -> fwd_hit_o=1, fwd_wdata_o=entry wdata; LOAD -> fwd_stall_o=1, hit=0; no match -> all 0.
//    Entry retiring this cycle still matches; entry enqueued this cycle does not.
// CONFIGURATION
//  IBEX_WB_FWD_EN defined: forwarding lookup as above.
//  Undefined: fwd_hit_o/fwd_stall_o/fwd_wdata_o tied 0, fwd_raddr_i unused, lookup logic absent.
// STRUCTURE
//  ibex_pkg: wb_instr_type_e, wb_entry_t {we, waddr, wdata, type, pc, compressed, count}.
//  Sub-module ibex_wb_fwd_lookup: age-ordered priority search over entries (head ptr, valid vector).
// TESTING
//  Depth=2: enqueue OTHER we=1 x5 wdata=0x11 -> next cycle rf_we_wb_o=1, rf_wdata_wb_o=0x11, instr_done_wb_o=1, count 1->0.
//  Enqueue LOAD x7 then OTHER; hold resp 3 cycles -> outstanding_load=1, OTHER blocked; resp rf_wdata_lsu_i=0xCAFE -> x7 written, OTHER retires next cycle.
//  Fill Depth=4 with STOREs -> ready_wb_o=0; resp + en_wb_i same cycle -> accepted, count stays 4.
//  LOAD resp with lsu_resp_err_i=1 -> instr_done_wb_o=1, perf_instr_ret_wb_o=0.
//  FWD_EN: queue OTHER x3=0xA then OTHER x3=0xB, fwd_raddr_i=3 -> hit, 0xB; LOAD x3 youngest -> stall=1; raddr 0 -> no hit.
//  Assert rst_ni low with 3 valid entries mid-load -> next cycle count_o=0, ready_wb_o=1, all other outputs 0.

Source files
------------

// File: rtl/ibex_wb_queue_pkg.sv
// Shared types for the multi-entry writeback queue.
// Defines the instruction class carried by each entry and the packed entry payload.
package ibex_wb_queue_pkg;

    localparam int unsigned RegAddrW = 5;
    localparam int unsigned DataW    = 32;

    typedef enum logic [1:0] {
        WB_INSTR_LOAD  = 2'd0,
        WB_INSTR_STORE = 2'd1,
        WB_INSTR_OTHER = 2'd2
    } wb_instr_type_e;

    typedef struct packed {
        logic                we;
        logic [RegAddrW-1:0] waddr;
        logic [DataW-1:0]    wdata;
        wb_instr_type_e      instr_type;
        logic [31:0]         pc;
        logic                compressed;
        logic                count;
    } wb_entry_t;

endpackage

// File: rtl/ibex_wb_fwd_lookup.sv
// Age-ordered forwarding search over the writeback queue entries.
// Walks entries oldest (head) to youngest so the youngest matching writer wins.
// Ports:
//   head_i     oldest entry index        valid_i/we_i/is_load_i  per-entry flags
//   waddr_i    per-entry RF address      wdata_i                 per-entry RF data
//   raddr_i    lookup address (x0 never matches)
//   hit_o      youngest writer is a non-load, wdata_o carries its data
//   stall_o    youngest writer is a load whose data is not yet known
module ibex_wb_fwd_lookup
    import ibex_wb_queue_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic [PtrW-1:0]                head_i,
    input  logic [Depth-1:0]               valid_i,
    input  logic [Depth-1:0]               we_i,
    input  logic [Depth-1:0]               is_load_i,
    input  logic [Depth-1:0][RegAddrW-1:0] waddr_i,
    input  logic [Depth-1:0][DataW-1:0]    wdata_i,
    input  logic [RegAddrW-1:0]            raddr_i,
    output logic                           hit_o,
    output logic                           stall_o,
    output logic [DataW-1:0]               wdata_o
);

    logic [PtrW:0]   sum;
    logic [PtrW-1:0] idx;

    // Later (younger) matches overwrite earlier ones.
    always_comb begin
        hit_o   = 1'b0;
        stall_o = 1'b0;
        wdata_o = '0;
        sum     = '0;
        idx     = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            sum = {1'b0, head_i} + (PtrW+1)'(i);
            if (sum >= (PtrW+1)'(Depth)) begin
                sum = sum - (PtrW+1)'(Depth);
            end
            idx = sum[PtrW-1:0];
            if (valid_i[idx] && we_i[idx] && (waddr_i[idx] == raddr_i) &&
                (raddr_i != '0)) begin
                hit_o   = ~is_load_i[idx];
                stall_o = is_load_i[idx];
                wdata_o = is_load_i[idx] ? '0 : wdata_i[idx];
            end
        end
    end

endmodule

// File: rtl/ibex_wb_queue.sv
// Multi-entry in-order writeback queue between ID/EX and the register file.
// Accepts one instruction per cycle, retires at most one per cycle from the head,
// merges LSU load data into the RF write port and reports retire perf events.
// Optional feature macro: IBEX_WB_FWD_EN enables the RF forwarding/hazard lookup
// over all queued entries; without it the fwd_* outputs are tied to 0.
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   en_wb_i + *_id_i, instr_type_wb_i  enqueue request and payload from EX
//   rf_wdata_lsu_i, rf_we_lsu_i        load data from the LSU
//   lsu_resp_valid_i, lsu_resp_err_i   LSU response for the head load/store
//   fwd_raddr_i                        forwarding lookup address
//   ready_wb_o                         enqueue accepted this cycle
//   rf_waddr/wdata/we_wb_o             RF write port (head entry)
//   outstanding_load/store_wb_o        any queued load/store
//   pc_wb_o, instr_done_wb_o           head PC, head retires this cycle
//   perf_instr_ret(_compressed)_wb_o   retire perf pulses
//   fwd_hit_o, fwd_stall_o, fwd_wdata_o forwarding result
//   count_o                            number of valid entries
module ibex_wb_queue
    import ibex_wb_queue_pkg::*;
#(
    parameter int unsigned Depth    = 2,
    parameter bit          ResetAll = 1'b0,
    localparam int unsigned PtrW    = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW    = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_wb_i,
    input  wb_instr_type_e      instr_type_wb_i,
    input  logic [31:0]         pc_id_i,
    input  logic                instr_is_compressed_id_i,
    input  logic                instr_perf_count_id_i,
    input  logic [RegAddrW-1:0] rf_waddr_id_i,
    input  logic [DataW-1:0]    rf_wdata_id_i,
    input  logic                rf_we_id_i,
    input  logic [DataW-1:0]    rf_wdata_lsu_i,
    input  logic                rf_we_lsu_i,
    input  logic                lsu_resp_valid_i,
    input  logic                lsu_resp_err_i,
    input  logic [RegAddrW-1:0] fwd_raddr_i,
    output logic                ready_wb_o,
    output logic [RegAddrW-1:0] rf_waddr_wb_o,
    output logic [DataW-1:0]    rf_wdata_wb_o,
    output logic                rf_we_wb_o,
    output logic                outstanding_load_wb_o,
    output logic                outstanding_store_wb_o,
    output logic [31:0]         pc_wb_o,
    output logic                instr_done_wb_o,
    output logic                perf_instr_ret_wb_o,
    output logic                perf_instr_ret_compressed_wb_o,
    output logic                fwd_hit_o,
    output logic                fwd_stall_o,
    output logic [DataW-1:0]    fwd_wdata_o,
    output logic [CntW-1:0]     count_o
);

    logic [Depth-1:0] valid_q, valid_d;
    logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]  count_q, count_d;
    wb_entry_t        entries_q [Depth];
    wb_entry_t        head_entry, enq_entry;
    logic             head_valid, head_done, head_rf_we, enq;

    assign head_valid = valid_q[head_q];
    assign head_entry = entries_q[head_q];
    // Non-memory instructions retire unconditionally; loads/stores wait for the LSU.
    assign head_done  = head_valid &
                        ((head_entry.instr_type == WB_INSTR_OTHER) | lsu_resp_valid_i);
    // A retiring head frees a slot in the same cycle, so a full queue never bubbles.
    assign ready_wb_o = (count_q < CntW'(Depth)) | head_done;
    assign enq        = en_wb_i & ready_wb_o;

    always_comb begin
        enq_entry            = '0;
        enq_entry.we         = rf_we_id_i;
        enq_entry.waddr      = rf_waddr_id_i;
        enq_entry.wdata      = rf_wdata_id_i;
        enq_entry.instr_type = instr_type_wb_i;
        enq_entry.pc         = pc_id_i;
        enq_entry.compressed = instr_is_compressed_id_i;
        enq_entry.count      = instr_perf_count_id_i;
    end

    // Pointer/valid/count next state; retire clears before enqueue sets so a full
    // queue can recycle the head slot as the new tail.
    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (head_done) begin
            valid_d[head_q] = 1'b0;
            head_d = (head_q == PtrW'(Depth - 1)) ? '0 : head_q + 1'b1;
        end
        if (enq) begin
            valid_d[tail_q] = 1'b1;
            tail_d = (tail_q == PtrW'(Depth - 1)) ? '0 : tail_q + 1'b1;
        end
        case ({enq, head_done})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage; reset only when ResetAll is set.
    if (ResetAll) begin : g_entries_rst
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int unsigned i = 0; i < Depth; i++) begin
                    entries_q[i] <= '0;
                end
            end else if (enq) begin
                entries_q[tail_q] <= enq_entry;
            end
        end
    end else begin : g_entries_nr
        always_ff @(posedge clk_i) begin
            if (enq) begin
                entries_q[tail_q] <= enq_entry;
            end
        end
    end

    // RF write port: loads write only through the LSU path.
    assign head_rf_we    = head_valid & head_entry.we & (head_entry.instr_type != WB_INSTR_LOAD);
    assign rf_we_wb_o    = head_rf_we | rf_we_lsu_i;
    assign rf_wdata_wb_o = ({DataW{head_rf_we}} & head_entry.wdata) |
                           ({DataW{rf_we_lsu_i}} & rf_wdata_lsu_i);
    assign rf_waddr_wb_o = head_valid ? head_entry.waddr : '0;
    assign pc_wb_o       = head_valid ? head_entry.pc : '0;

    assign instr_done_wb_o                = head_done;
    assign perf_instr_ret_wb_o            = head_done & head_entry.count &
                                            ~(lsu_resp_valid_i & lsu_resp_err_i);
    assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & head_entry.compressed;
    assign count_o                        = count_q;

    always_comb begin
        outstanding_load_wb_o  = 1'b0;
        outstanding_store_wb_o = 1'b0;
        for (int unsigned i = 0; i < Depth; i++) begin
            if (valid_q[i] && (entries_q[i].instr_type == WB_INSTR_LOAD)) begin
                outstanding_load_wb_o = 1'b1;
            end
            if (valid_q[i] && (entries_q[i].instr_type == WB_INSTR_STORE)) begin
                outstanding_store_wb_o = 1'b1;
            end
        end
    end

`ifdef IBEX_WB_FWD_EN
    logic [Depth-1:0]               fwd_we, fwd_is_load;
    logic [Depth-1:0][RegAddrW-1:0] fwd_waddr;
    logic [Depth-1:0][DataW-1:0]    fwd_wdata;

    always_comb begin
        for (int unsigned i = 0; i < Depth; i++) begin
            fwd_we[i]      = entries_q[i].we;
            fwd_is_load[i] = (entries_q[i].instr_type == WB_INSTR_LOAD);
            fwd_waddr[i]   = entries_q[i].waddr;
            fwd_wdata[i]   = entries_q[i].wdata;
        end
    end

    ibex_wb_fwd_lookup #(
        .Depth (Depth),
        .PtrW  (PtrW)
    ) u_fwd_lookup (
        .head_i    (head_q),
        .valid_i   (valid_q),
        .we_i      (fwd_we),
        .is_load_i (fwd_is_load),
        .waddr_i   (fwd_waddr),
        .wdata_i   (fwd_wdata),
        .raddr_i   (fwd_raddr_i),
        .hit_o     (fwd_hit_o),
        .stall_o   (fwd_stall_o),
        .wdata_o   (fwd_wdata_o)
    );
`else
    logic unused_fwd_raddr;
    assign unused_fwd_raddr = ^fwd_raddr_i;
    assign fwd_hit_o        = 1'b0;
    assign fwd_stall_o      = 1'b0;
    assign fwd_wdata_o      = '0;
`endif

`ifndef SYNTHESIS
    // Enqueue while not ready is a protocol violation by the issuing stage.
    a_enq_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
        en_wb_i |-> ready_wb_o)
        else $error("ibex_wb_queue: en_wb_i asserted while ready_wb_o low");

    // LSU responses are only meaningful for a queued load/store at the head.
    a_lsu_resp_head: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lsu_resp_valid_i |-> (head_valid && (head_entry.instr_type != WB_INSTR_OTHER)))
        else $error("ibex_wb_queue: LSU response without load/store at head");
`endif

endmodule
